// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared state encoding, counter width and tolerance helper for the clock period monitor
package clk_mon_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_e;

    // Absolute difference is formed one bit wider than the operands so a
    // small measured period against a large expected one cannot wrap into
    // a falsely small deviation.
    function automatic logic within_tol(
        input logic [CNT_W-1:0] meas,
        input logic [CNT_W-1:0] expv,
        input logic [3:0]       tol
    );
        logic [CNT_W:0] diff;
        if (meas >= expv) begin
            diff = {1'b0, meas} - {1'b0, expv};
        end else begin
            diff = {1'b0, expv} - {1'b0, meas};
        end
        return diff <= {{(CNT_W - 3){1'b0}}, tol};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with one-flop edge detector for an asynchronous clock input
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_12mhz,
    input  logic rst,
    input  logic clk_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchronizer chain; prev_q holds the
    // previous synchronized level for edge detection.
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - measures clk_in period/high time and tracks lock against an expected period
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_12mhz,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [3:0]       tolerance,
    output logic             rise_stb,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    logic lvl;
    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_12mhz(clk_12mhz),
        .rst      (rst),
        .clk_in   (clk_in),
        .level    (lvl),
        .rise     (rise),
        .fall     (fall)
    );

    mon_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_len_q;
    logic [3:0]       good_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             rise_stb_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             fault_q;

    logic       in_tol;
    logic [3:0] good_d;

    // Tolerance verdict on the period about to be published, and the
    // saturating good-period count that would follow a pass.
    always_comb begin
        in_tol = within_tol(cnt_q, exp_period, tolerance);
        good_d = (good_q >= LOCK_N) ? LOCK_N : good_q + 4'd1;
    end

    // Monitor FSM with its counters and all registered outputs.
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_cnt_q     <= '0;
            hi_len_q     <= '0;
            good_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            rise_stb_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            rise_stb_q   <= rise;
            meas_valid_q <= 1'b0;
            if (!enable) begin
                // period/high_time deliberately hold their last values.
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                hi_cnt_q <= '0;
                hi_len_q <= '0;
                good_q   <= '0;
                locked_q <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q    <= '0;
                        hi_cnt_q <= '0;
                        hi_len_q <= '0;
                        good_q   <= '0;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b0;
                        state_q  <= ST_ARM;
                    end
                    ST_ARM: begin
                        // First edge only starts the count; there is no
                        // complete period to report yet.
                        if (rise) begin
                            cnt_q    <= 8'd1;
                            hi_cnt_q <= 8'd1;
                            state_q  <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        // High phase is captured when it ends so the value
                        // is ready for the next rising edge.
                        if (fall) begin
                            hi_len_q <= hi_cnt_q;
                        end
                        if (cnt_q == CNT_MAX) begin
                            // Timeout beats a coincident rising edge.
                            fault_q  <= 1'b1;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                            state_q  <= ST_ARM;
                        end else if (rise) begin
                            period_q     <= cnt_q;
                            high_time_q  <= hi_len_q;
                            meas_valid_q <= 1'b1;
                            cnt_q        <= 8'd1;
                            hi_cnt_q     <= 8'd1;
                            if (in_tol) begin
                                good_q <= good_d;
                                if (good_d == LOCK_N) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                good_q   <= '0;
                                locked_q <= 1'b0;
                                fault_q  <= 1'b1;
                                state_q  <= ST_MEASURE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                            if (lvl && (hi_cnt_q != CNT_MAX)) begin
                                hi_cnt_q <= hi_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rise_stb   = rise_stb_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb/tb_clk_period_monitor.sv - self-checking bench for clk_period_monitor
module tb_clk_period_monitor;

    logic       clk_12mhz;
    logic       rst;
    logic       clk_in;
    logic       enable;
    logic [7:0] exp_period;
    logic [3:0] tolerance;
    logic       rise_stb;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       locked;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    int gen_hi  = 6;
    int gen_lo  = 6;
    bit gen_run = 0;

    typedef struct {
        int hi;
        int lo;
        int exp_p;
        int tol;
        bit in_tol;
    } vec_t;

    vec_t tbl[8];

    clk_period_monitor #(
        .SYNC_STAGES(2),
        .LOCK_COUNT (4)
    ) dut (
        .clk_12mhz (clk_12mhz),
        .rst       (rst),
        .clk_in    (clk_in),
        .enable    (enable),
        .exp_period(exp_period),
        .tolerance (tolerance),
        .rise_stb  (rise_stb),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .fault     (fault)
    );

    initial begin
        clk_12mhz = 1'b0;
        forever #5 clk_12mhz = ~clk_12mhz;
    end

    // clk_in pattern generator; high/low lengths are latched at each period start
    initial begin : gen
        int ph;
        int cur_hi;
        int cur_lo;
        clk_in = 1'b0;
        ph     = 0;
        cur_hi = 6;
        cur_lo = 6;
        forever begin
            @(posedge clk_12mhz);
            #1;
            if (!gen_run) begin
                clk_in = 1'b0;
                ph     = 0;
            end else begin
                if (ph == 0) begin
                    cur_hi = gen_hi;
                    cur_lo = gen_lo;
                end
                clk_in = (ph < cur_hi);
                ph     = (ph + 1 >= cur_hi + cur_lo) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
        end
    endtask

    task automatic wait_meas(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_12mhz);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_checks(input int hi, input int lo, input bit in_tol,
                              input bit exp_fault, input int nmeas);
        bit ok;
        for (int k = 1; k <= nmeas; k++) begin
            wait_meas(ok);
            chk("meas_timeout", int'(ok), 1);
            if (!ok) return;
            chk("period", int'(period), hi + lo);
            chk("high_time", int'(high_time), hi);
            chk("rise_stb_with_meas", int'(rise_stb), 1);
            chk("fault", int'(fault), int'(exp_fault));
            if (k == 3) chk("locked_before_4", int'(locked), 0);
            if (k == 4) begin
                @(negedge clk_12mhz);
                chk("locked_after_4", int'(locked), int'(in_tol));
            end
        end
    endtask

    task automatic fresh_start(input int hi, input int lo, input int ep, input int tl);
        gen_run = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk_12mhz);
        exp_period = 8'(ep);
        tolerance  = 4'(tl);
        gen_hi     = hi;
        gen_lo     = lo;
        enable     = 1'b1;
        repeat (2) @(negedge clk_12mhz);
        gen_run = 1'b1;
    endtask

    initial begin : main
        bit ok;
        tbl[0] = '{hi: 6,   lo: 6,   exp_p: 12,  tol: 1,  in_tol: 1'b1};
        tbl[1] = '{hi: 6,   lo: 7,   exp_p: 12,  tol: 1,  in_tol: 1'b1};
        tbl[2] = '{hi: 7,   lo: 7,   exp_p: 12,  tol: 1,  in_tol: 1'b0};
        tbl[3] = '{hi: 3,   lo: 5,   exp_p: 10,  tol: 2,  in_tol: 1'b1};
        tbl[4] = '{hi: 4,   lo: 4,   exp_p: 250, tol: 15, in_tol: 1'b0};
        tbl[5] = '{hi: 10,  lo: 10,  exp_p: 21,  tol: 0,  in_tol: 1'b0};
        tbl[6] = '{hi: 10,  lo: 10,  exp_p: 20,  tol: 0,  in_tol: 1'b1};
        tbl[7] = '{hi: 100, lo: 100, exp_p: 200, tol: 0,  in_tol: 1'b1};

        rst        = 1'b1;
        enable     = 1'b0;
        exp_period = 8'd12;
        tolerance  = 4'd1;
        gen_run    = 1'b1;
        repeat (20) @(negedge clk_12mhz);
        chk("rst_period", int'(period), 0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_rise_stb", int'(rise_stb), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        gen_run = 1'b0;
        repeat (2) @(negedge clk_12mhz);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            fresh_start(tbl[r].hi, tbl[r].lo, tbl[r].exp_p, tbl[r].tol);
            run_checks(tbl[r].hi, tbl[r].lo, tbl[r].in_tol, !tbl[r].in_tol, 5);
        end

        // Lock, one 15-cycle period, then relock with fault held
        fresh_start(6, 6, 12, 1);
        run_checks(6, 6, 1'b1, 1'b0, 5);
        gen_hi = 8;
        gen_lo = 7;
        wait_meas(ok);
        chk("meas_timeout", int'(ok), 1);
        chk("pre_step_period", int'(period), 12);
        gen_hi = 6;
        gen_lo = 6;
        wait_meas(ok);
        chk("meas_timeout", int'(ok), 1);
        chk("step_period", int'(period), 15);
        chk("step_high_time", int'(high_time), 8);
        chk("step_locked", int'(locked), 0);
        chk("step_fault", int'(fault), 1);
        run_checks(6, 6, 1'b1, 1'b1, 4);

        // Locked, then clk_in stops: timeout exactly 255 cycles after restart
        fresh_start(6, 6, 12, 1);
        run_checks(6, 6, 1'b1, 1'b0, 5);
        gen_run = 1'b0;
        begin : timeout_seq
            int mv = 0;
            for (int i = 0; i < 254; i++) begin
                @(negedge clk_12mhz);
                if (meas_valid) mv++;
            end
            chk("to_fault_254", int'(fault), 0);
            chk("to_locked_254", int'(locked), 1);
            @(negedge clk_12mhz);
            if (meas_valid) mv++;
            chk("to_fault_255", int'(fault), 1);
            chk("to_locked_255", int'(locked), 0);
            chk("to_no_meas", mv, 0);
        end
        gen_run = 1'b1;
        run_checks(6, 6, 1'b1, 1'b1, 1);

        // enable dropped mid-MEASURE, then re-enabled
        repeat (3) @(negedge clk_12mhz);
        enable = 1'b0;
        @(negedge clk_12mhz);
        chk("dis_locked", int'(locked), 0);
        chk("dis_fault", int'(fault), 0);
        chk("dis_period_hold", int'(period), 12);
        chk("dis_high_hold", int'(high_time), 6);
        repeat (5) @(negedge clk_12mhz);
        enable = 1'b1;
        run_checks(6, 6, 1'b1, 1'b0, 5);

        // rst during high phase while locked
        @(negedge clk_12mhz);
        chk("pre_rst_clk_high", int'(dut.lvl), 1);
        rst = 1'b1;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_high_time", int'(high_time), 0);
        chk("arst_rise_stb", int'(rise_stb), 0);
        chk("arst_meas_valid", int'(meas_valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_fault", int'(fault), 0);
        gen_run = 1'b0;
        repeat (4) @(negedge clk_12mhz);
        rst = 1'b0;
        repeat (2) @(negedge clk_12mhz);
        gen_run = 1'b1;
        run_checks(6, 6, 1'b1, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
